// File: rtl/keypad_pkg.sv
`default_nettype none
// keypad_pkg: shared sizes, key bit assignments and row/col-to-bit mapping (rev 1.0)
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam int KEY_D1  = 0;
  localparam int KEY_D2  = 1;
  localparam int KEY_D3  = 2;
  localparam int KEY_D4  = 3;
  localparam int KEY_D5  = 4;
  localparam int KEY_D6  = 5;
  localparam int KEY_D7  = 6;
  localparam int KEY_D8  = 7;
  localparam int KEY_D9  = 8;
  localparam int KEY_D0  = 9;
  localparam int KEY_CLR = 10;
  localparam int KEY_ENT = 11;

  typedef enum logic [1:0] {
    COL_0 = 2'd0,
    COL_1 = 2'd1,
    COL_2 = 2'd2
  } col_e;

  typedef logic [NUM_KEYS-1:0] keys_t;

  function automatic logic [3:0] key_bit(input int row, input int col);
    int k;
    case (row * NUM_COLS + col)
      0:       k = KEY_D1;
      1:       k = KEY_D2;
      2:       k = KEY_D3;
      3:       k = KEY_D4;
      4:       k = KEY_D5;
      5:       k = KEY_D6;
      6:       k = KEY_D7;
      7:       k = KEY_D8;
      8:       k = KEY_D9;
      9:       k = KEY_CLR;
      10:      k = KEY_D0;
      default: k = KEY_ENT;
    endcase
    return 4'(k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// sync_2ff: two-flop synchronizer for asynchronous level inputs (rev 1.0)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// keypad_scan: 4x3 keypad column scanner with frame debounce and one-hot press pulses (rev 1.0)
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                I2C_clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [NUM_KEYS-1:0] button_ord,
  output logic                key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] rows_sync_n;

  logic             run_q,   run_d;
  col_e             col_q,   col_d;
  logic [DIV_W-1:0] div_q,   div_d;
  keys_t            snap_q,  snap_d;
  keys_t            last_q,  last_d;
  keys_t            acc_q,   acc_d;
  keys_t            ord_q,   ord_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             armed_q, armed_d;
  logic             upd_q,   upd_d;
  logic             kd_q,    kd_d;
  logic             slot_end;
  logic             frame_end;

  sync_2ff #(
    .WIDTH   (NUM_ROWS),
    .RST_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk_i (I2C_clk),
    .rst_i (rst),
    .d_i   (row_n),
    .q_o   (rows_sync_n)
  );

  always_ff @(posedge I2C_clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      col_q   <= COL_0;
      div_q   <= '0;
      snap_q  <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      ord_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      upd_q   <= 1'b0;
      kd_q    <= 1'b0;
    end else begin
      run_q   <= run_d;
      col_q   <= col_d;
      div_q   <= div_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      ord_q   <= ord_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      upd_q   <= upd_d;
      kd_q    <= kd_d;
    end
  end

  always_comb begin
    run_d   = run_q;
    col_d   = col_q;
    div_d   = div_q;
    snap_d  = snap_q;
    last_d  = last_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    kd_d    = kd_q;
    upd_d   = 1'b0;
    ord_d   = '0;

    slot_end  = run_q && (div_q == c_div_last);
    frame_end = slot_end && (col_q == COL_2);

    // run_q holds the columns idle for the reset cycle, so column 0 gets a full slot
    if (!run_q) begin
      run_d = 1'b1;
    end else if (slot_end) begin
      div_d = '0;
      col_d = (col_q == COL_2) ? COL_0 : col_e'(col_q + 2'd1);
    end else begin
      div_d = div_q + 1'b1;
    end

    if (slot_end) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_d[key_bit(r, int'(col_q))] = ~rows_sync_n[r];
      end
    end

    // Debounce uses the frame including the column sampled on this very cycle
    if (frame_end) begin
      if (snap_d == last_q) begin
        cnt_d = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
      last_d = snap_d;
      if (cnt_d == c_cnt_max) begin
        acc_d = snap_d;
        kd_d  = |snap_d;
        upd_d = 1'b1;
      end
    end

    // Any accepted non-empty frame disarms, so rollover out of a chord stays silent
    if (upd_q) begin
      if (acc_q == '0) begin
        armed_d = 1'b1;
      end else begin
        if (armed_q && ((acc_q & (acc_q - 1'b1)) == '0)) begin
          ord_d = acc_q;
        end
        armed_d = 1'b0;
      end
    end
  end

  always_comb begin
    col_n = '1;
    if (run_q) begin
      case (col_q)
        COL_0:   col_n = 3'b110;
        COL_1:   col_n = 3'b101;
        COL_2:   col_n = 3'b011;
        default: col_n = 3'b111;
      endcase
    end
  end

  assign button_ord = ord_q;
  assign key_down   = kd_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// tb_keypad_scan: randomized keypad stimulus checked every cycle against a frame-level model
module tb_keypad_scan;

  localparam int SD = 8;
  localparam int DB = 3;
  localparam int FR = 3 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [11:0] button_ord;
  logic        key_down;
  logic [11:0] phys = '0;   // pressed keys, index row*3+col

  int errors = 0;
  int checks = 0;
  logic [11:0] pulses[$];

  // keypad bit for each physical position row*3+col
  int bitmap[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 9, 11};

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .I2C_clk    (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .button_ord (button_ord),
    .key_down   (key_down)
  );

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (col_n[c] === 1'b0 && phys[r*3+c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model
  bit          m_started = 0;
  bit          m_run = 0;
  int          m_cyc = 0;
  logic [3:0]  m_s1 = '1, m_s2 = '1;
  logic [11:0] m_snap = '0, m_last = '0, m_acc = '0, m_ord = '0;
  int          m_cnt = 0;
  bit          m_armed = 1, m_pend = 0, m_kd = 0;

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_started = 1; m_run = 0; m_cyc = 0;
      m_s1 = '1; m_s2 = '1;
      m_snap = '0; m_last = '0; m_acc = '0; m_ord = '0;
      m_cnt = 0; m_armed = 1; m_pend = 0; m_kd = 0;
    end else begin
      m_ord = '0;
      if (m_pend) begin
        if (m_acc == 0) m_armed = 1;
        else begin
          if (m_armed && $countones(m_acc) == 1) m_ord = m_acc;
          m_armed = 0;
        end
      end
      m_pend = 0;
      if (m_run) begin
        p = m_cyc % FR;
        if (p % SD == SD - 1)
          for (int r = 0; r < 4; r++) m_snap[bitmap[r*3 + p/SD]] = ~m_s2[r];
        if (p == FR - 1) begin
          if (m_snap == m_last) m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
          else m_cnt = 0;
          m_last = m_snap;
          if (m_cnt == DB) begin
            m_acc = m_snap; m_kd = |m_snap; m_pend = 1;
          end
        end
        m_cyc++;
      end else begin
        m_run = 1;
      end
      m_s2 = m_s1;
      m_s1 = row_n;
    end
  end

  always @(negedge clk) begin
    logic [2:0] ecol;
    if (m_started) begin
      ecol = m_run ? ~(3'b001 << ((m_cyc % FR) / SD)) : 3'b111;
      chk("col_n", {9'd0, col_n}, {9'd0, ecol});
      chk("button_ord", button_ord, m_ord);
      chk("key_down", {11'd0, key_down}, {11'd0, m_kd});
      if (button_ord != 0) pulses.push_back(button_ord);
    end
  end

  task automatic hold(input int frames);
    repeat (frames * FR) @(negedge clk);
  endtask

  initial begin
    int k4[3];
    logic [11:0] e4[3];
    int sel;
    k4 = '{9, 10, 11};
    e4 = '{12'h400, 12'h200, 12'h800};

    // reset and scan order
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_col", {9'd0, col_n}, 12'h007);
    chk("rst_ord", button_ord, 12'h000);
    chk("rst_kd", {11'd0, key_down}, 12'h000);
    rst = 1'b0;
    @(negedge clk);
    chk("scan_c0", {9'd0, col_n}, 12'h006);
    repeat (SD) @(negedge clk);
    chk("scan_c1", {9'd0, col_n}, 12'h005);
    repeat (SD) @(negedge clk);
    chk("scan_c2", {9'd0, col_n}, 12'h003);
    repeat (SD) @(negedge clk);
    chk("scan_wrap", {9'd0, col_n}, 12'h006);

    // hold '5'
    pulses.delete();
    phys = 12'h010;
    hold(10);
    chk("hold5_kd", {11'd0, key_down}, 12'h001);
    chk("hold5_cnt", 12'(pulses.size()), 12'd1);
    chk("hold5_val", pulses[0], 12'h010);
    phys = '0;
    hold(6);
    chk("rel5_kd", {11'd0, key_down}, 12'h000);
    chk("rel5_cnt", 12'(pulses.size()), 12'd1);

    // bouncing '2'
    pulses.delete();
    for (int i = 0; i < 12; i++) begin
      phys[1] = ~phys[1];
      repeat (5) @(negedge clk);
    end
    chk("bounce_none", 12'(pulses.size()), 12'd0);
    phys = 12'h002;
    hold(6);
    chk("bounce_cnt", 12'(pulses.size()), 12'd1);
    chk("bounce_val", pulses[0], 12'h002);
    phys = '0;
    hold(6);

    // '*', '0', '#'
    pulses.delete();
    for (int i = 0; i < 3; i++) begin
      phys = 12'(1) << k4[i];
      hold(6);
      phys = '0;
      hold(6);
    end
    chk("spec_cnt", 12'(pulses.size()), 12'd3);
    for (int i = 0; i < 3; i++) chk("spec_val", pulses[i], e4[i]);

    // chord, rollover, then '3'
    pulses.delete();
    phys = 12'h003;
    hold(6);
    chk("chord_none", 12'(pulses.size()), 12'd0);
    phys = 12'h001;
    hold(6);
    chk("roll_none", 12'(pulses.size()), 12'd0);
    phys = '0;
    hold(6);
    phys = 12'h004;
    hold(6);
    chk("key3_cnt", 12'(pulses.size()), 12'd1);
    chk("key3_val", pulses[0], 12'h004);
    phys = '0;
    hold(6);

    // reset with '9' held
    phys = 12'h100;
    hold(1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ord", button_ord, 12'h000);
    chk("mid_rst_kd", {11'd0, key_down}, 12'h000);
    chk("mid_rst_col", {9'd0, col_n}, 12'h007);
    rst = 1'b0;
    pulses.delete();
    hold(5);
    chk("post_rst_cnt", 12'(pulses.size()), 12'd1);
    chk("post_rst_val", pulses[0], 12'h100);
    phys = '0;
    hold(6);

    // randomized presses, chords and bounces
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) phys = '0;
      else if (sel < 8) phys = 12'(1) << $urandom_range(0, 11);
      else phys = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 6; b++) begin
          phys = phys ^ (12'(1) << $urandom_range(0, 11));
          repeat ($urandom_range(1, 7)) @(negedge clk);
        end
      end
      repeat ($urandom_range(10, 150)) @(negedge clk);
    end
    phys = '0;
    hold(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
